// File: rtl/nonce_tx_packer_if.sv
// Nonce-in / UART-out bundle for the nonce packer.
// slave: the packer side; master: hash cores plus the UART transmitter.
interface nonce_tx_packer_if;
  logic [31:0] nonce_in;
  logic        nonce_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_new_data;

  modport slave (
    input  nonce_in,
    input  nonce_valid,
    input  tx_busy,
    output tx_data,
    output tx_new_data
  );

  modport master (
    output nonce_in,
    output nonce_valid,
    output tx_busy,
    input  tx_data,
    input  tx_new_data
  );
endinterface

// File: rtl/nonce_tx_packer.sv
// Queues golden nonces and streams them MSB-first to the UART transmitter.
// Define NONCE_TX_CHECKSUM_EN to append an XOR checksum byte per nonce.
module nonce_tx_packer #(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  nonce_tx_packer_if.slave   bus,
  output logic [PTR_W:0]     fifo_count,
  output logic               overflow,
  output logic               idle
);

`ifdef NONCE_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int SR_W = NB * 8;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    HOLD = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t            state;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [SR_W-1:0]   sreg;
  logic [2:0]        byte_idx;
  logic [31:0]       head;
  logic              full;
  logic              push;
  logic              pop;

  assign head = mem[rd_ptr];
  // full uses the pre-edge count, so a same-cycle pop never frees the slot
  assign full = (fifo_count == FULL_CNT);
  assign push = bus.nonce_valid && !full;
  assign pop  = (state == LOAD);
  assign idle = (state == IDLE) && (fifo_count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.nonce_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.nonce_valid && full) begin
        overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      byte_idx        <= '0;
      sreg            <= '0;
      bus.tx_data     <= '0;
      bus.tx_new_data <= 1'b0;
    end else begin
      bus.tx_new_data <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            state <= LOAD;
          end
        end
        LOAD: begin
`ifdef NONCE_TX_CHECKSUM_EN
          sreg <= {head, head[31:24] ^ head[23:16]
                       ^ head[15:8] ^ head[7:0]};
`else
          sreg <= head;
`endif
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_data     <= sreg[SR_W-1 -: 8];
            bus.tx_new_data <= 1'b1;
            state           <= HOLD;
          end
        end
        // UART raises busy one cycle after the strobe
        HOLD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (!bus.tx_busy) begin
            if (byte_idx == LAST_IDX) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              sreg     <= sreg << 8;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_tx_packer.sv
// Directed bench for nonce_tx_packer with a CLK_PER_BIT=4 UART busy model.
// Honours NONCE_TX_CHECKSUM_EN for the expected byte stream.
module tb_nonce_tx_packer;
`ifdef NONCE_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nonce_tx_packer_if bus();

  logic       uart_busy  = 1'b0;
  int         uart_cnt   = 0;
  logic       busy_force = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       idle;

  assign bus.tx_busy = uart_busy | busy_force;

  nonce_tx_packer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .idle       (idle)
  );

  // registered busy: rises the cycle after the strobe, 10 bits long
  always @(posedge clk) begin
    if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_busy <= 1'b0;
    end else if (bus.tx_new_data) begin
      uart_busy <= 1'b1;
      uart_cnt  <= 10 * CPB;
    end
  end

  logic [7:0] got_q[$];
  int         gap_q[$];
  logic [7:0] exp_q[$];
  int         cyc      = 0;
  int         fall_cyc = 0;
  int         n_dbl    = 0;
  int         n_viol   = 0;
  logic       prev_nd  = 1'b0;
  logic       prev_bsy = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_nd  <= bus.tx_new_data;
    prev_bsy <= bus.tx_busy;
    if (prev_bsy && !bus.tx_busy) fall_cyc <= cyc;
    if (bus.tx_new_data) begin
      got_q.push_back(bus.tx_data);
      gap_q.push_back(cyc - fall_cyc);
      if (prev_nd)     n_dbl  <= n_dbl + 1;
      if (bus.tx_busy) n_viol <= n_viol + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] n);
    @(negedge clk);
    bus.nonce_in    = n;
    bus.nonce_valid = 1'b1;
    @(negedge clk);
    bus.nonce_valid = 1'b0;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic exp_nonce(input logic [31:0] n);
    exp_q.push_back(n[31:24]);
    exp_q.push_back(n[23:16]);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
`ifdef NONCE_TX_CHECKSUM_EN
    exp_q.push_back(n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
`endif
  endtask

  task automatic check_bytes(input string tag, input int base);
    chk({tag, "_n"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size())
        chk({tag, "_b"}, got_q[base+i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    repeat (3) @(negedge clk);
    while (!(idle && !bus.tx_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, n < 5000, 1);
  endtask

  task automatic wait_strobes(input string tag, input int base,
                              input int k);
    int n = 0;
    while (got_q.size() - base < k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_strb"}, n < 2000, 1);
  endtask

  task automatic pop_push(input string tag, input int nq,
                          input int cnt_after, input logic ovf);
    int base = got_q.size();
    int n = 0;
    busy_force = 1'b1;
    put(32'hA0A0_A0A0);
    exp_nonce(32'hA0A0_A0A0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < nq; i++) begin
      put(32'h10 + 32'(i));
      exp_nonce(32'h10 + 32'(i));
    end
    chk({tag, "_pre"}, fifo_count, nq);
    busy_force = 1'b0;
    wait_strobes(tag, base, NB);
    while (bus.tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    // WAIT->IDLE, IDLE->LOAD, then write lands in the LOAD cycle
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.nonce_in    = 32'hCAFE_F00D;
    bus.nonce_valid = 1'b1;
    @(negedge clk);
    bus.nonce_valid = 1'b0;
    chk({tag, "_cnt"}, fifo_count, cnt_after);
    chk({tag, "_ovf"}, overflow, ovf);
    if (nq < 4) exp_nonce(32'hCAFE_F00D);
    wait_done(tag);
    check_bytes(tag, base);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base;
    int lat;
    int n;
    bus.nonce_in    = '0;
    bus.nonce_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_nd",   bus.tx_new_data, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_cnt",  fifo_count, 0);
    chk("rst_ovf",  overflow, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;

    base = got_q.size();
    put(32'hDEAD_BEEF);
    lat = 0;
    while (!bus.tx_new_data && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("lat", lat, 3);
    wait_done("single");
    exp_nonce(32'hDEAD_BEEF);
    check_bytes("single", base);
    chk("single_idle", idle, 1);

    base = got_q.size();
    busy_force = 1'b1;
    put(32'hA0A0_A0A0);
    exp_nonce(32'hA0A0_A0A0);
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 5; i++) put(32'(i));
    for (int i = 1; i <= 4; i++) exp_nonce(32'(i));
    chk("full_cnt", fifo_count, 4);
    chk("full_ovf", overflow, 1);
    chk("full_quiet", got_q.size() - base, 0);
    busy_force = 1'b0;
    wait_done("full");
    check_bytes("full", base);

    do_rst();
    chk("clr_ovf", overflow, 0);
    pop_push("pp4", 4, 3, 1'b1);
    do_rst();
    pop_push("pp2", 2, 2, 1'b0);

    base = got_q.size();
    put(32'h1122_3344);
    put(32'h5566_7788);
    wait_strobes("mid", base, 2);
    chk("mid_pre", fifo_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_cnt", fifo_count, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_nd",  bus.tx_new_data, 0);
    n = 0;
    while (bus.tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_idle", idle, 1);
    repeat (100) @(negedge clk);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    check_bytes("mid", base);

    base = got_q.size();
    put(32'hDEAD_BEEF);
    wait_strobes("bp", base, 1);
    busy_force = 1'b1;
    repeat (20) @(negedge clk);
    busy_force = 1'b0;
    wait_done("bp");
    exp_nonce(32'hDEAD_BEEF);
    check_bytes("bp", base);
    if (base + 1 < gap_q.size())
      chk("bp_gap", gap_q[base+1], 2);
    else
      chk("bp_gap_miss", 0, 1);

    chk("dbl_pulse", n_dbl, 0);
    chk("busy_pulse", n_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
